// File: rtl/uart_rx_ovsamp.sv
// -----------------------------------------------------------------------------
// uart_rx_ovsamp
//
// 8x-oversampling UART receiver for 8N1 frames, LSB first. The asynchronous
// serial input goes through a two-flop synchronizer. A tick divider produces
// eight sample ticks per bit period. Each received byte goes into a
// single-entry buffer that the consumer drains over a valid/ready handshake.
// A stop bit sampled low raises a one-cycle framing-error pulse. The receiver
// then ignores the line until it returns high. A byte that completes while the
// buffer is still full is dropped and raises a one-cycle overrun pulse.
//
// Optional feature macro: UART_RX_MAJORITY_EN
//   When defined, each bit decision is a 2-of-3 majority vote. The three votes
//   are the rxs samples from the two ticks before the decision tick and the
//   sample at the decision tick. The decision point is unchanged, so latency
//   is the same.
//   When undefined, each bit is a single sample taken at the decision tick.
//
// Parameters
//   CLK_RATE    system clock frequency in Hz
//   BAUD_RATE   line rate in bit/s; CLK_RATE must exceed 8*BAUD_RATE
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        synchronous reset, active-high
//   rx_i         asynchronous serial input, idle high
//   dout_o       received byte, stable while valid_o is high
//   valid_o      dout_o holds an unconsumed byte
//   ready_i      consumer takes dout_o when valid_o && ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    one-cycle pulse: byte completed while buffer full, byte lost
// -----------------------------------------------------------------------------
module uart_rx_ovsamp #(
    parameter int unsigned CLK_RATE  = 100_000_000,
    parameter int unsigned BAUD_RATE = 115_200
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic [7:0] dout_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int unsigned DIV_RAW = CLK_RATE / (8 * BAUD_RATE);
    localparam int unsigned DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);

    if (CLK_RATE <= 8 * BAUD_RATE) begin : g_rate_check
        $error("uart_rx_ovsamp: CLK_RATE must exceed 8*BAUD_RATE");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_e;

    state_e           state_q, state_d;
    logic             sync1_q;
    logic             rxs_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       samp_q, samp_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       dout_q, dout_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;

    logic tick;
    logic bit_val;

    assign tick = (div_q == DIV_MAX);

`ifdef UART_RX_MAJORITY_EN
    // hist_q[0] holds the sample from the most recent tick, hist_q[1] the one before it.
    logic [1:0] hist_q, hist_d;

    assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
    assign bit_val = rxs_q;
`endif

    always_comb begin
        // NOTE: every next-state value starts from a hold default so no branch can infer a latch.
        state_d     = state_q;
        div_d       = div_q;
        samp_d      = samp_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;
`ifdef UART_RX_MAJORITY_EN
        hist_d      = hist_q;
`endif

        // The consumer takes the buffered byte. A delivery below can refill the buffer in this same cycle.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        // The oversampling timebase runs only while a frame is in progress.
        if (state_q == S_IDLE || state_q == S_BREAK) begin
            div_d  = '0;
            samp_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + DIV_W'(1);
            if (tick) begin
                samp_d = samp_q + 3'd1;
            end
`ifdef UART_RX_MAJORITY_EN
            if (tick) begin
                hist_d = {hist_q[0], rxs_q};
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                // Sample count 3 is the middle of the start bit.
                // A high line there means the falling edge was a glitch.
                if (tick && samp_q == 3'd3) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                    end else begin
                        samp_d  = '0;
                        bit_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                // Because the sample counter restarted at mid start bit, count 7 is mid-bit.
                if (tick && samp_q == 3'd7) begin
                    shift_d = {bit_val, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end

            S_STOP: begin
                if (tick && samp_q == 3'd7) begin
                    if (bit_val) begin
                        state_d = S_IDLE;
                        if (!valid_q || ready_i) begin
                            dout_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                // Wait here so a line held low cannot look like a new start bit.
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: all state is registered with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            div_q       <= '0;
            samp_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
            hist_q      <= 2'b11;
`endif
        end else begin
            sync1_q     <= rx_i;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            div_q       <= div_d;
            samp_q      <= samp_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef UART_RX_MAJORITY_EN
            hist_q      <= hist_d;
`endif
        end
    end

    assign dout_o      = dout_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

endmodule
